// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, reads imem port A, and feeds decode
// through a 2-entry prefetch buffer with redirect and fault handling.
module if_stage #(
    parameter int          WADDR    = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n_i,
    output logic             imem_en_o,
    output logic [WADDR-1:0] imem_addr_o,
    output logic [3:0]       imem_we_o,
    output logic [31:0]      imem_data_o,
    input  logic [31:0]      imem_data_i,
    input  logic             redirect_i,
    input  logic [31:0]      redirect_pc_i,
    output logic             instr_valid_o,
    input  logic             instr_ready_i,
    output logic [31:0]      instr_o,
    output logic [31:0]      instr_pc_o,
    output logic             fault_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FAULT
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [31:0] LAST_PC = 32'((64'd1 << WADDR) - 64'd4);

    state_t      state_q;
    logic [31:0] pc_q;
    logic [1:0]  count_q;
    entry_t      buf0_q;
    entry_t      buf1_q;

    logic   pop;
    logic   push;
    logic   redir_ok;
    entry_t new_e;

    assign instr_valid_o = (count_q != 2'd0) && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;
    assign push          = (state_q == RUN) && !redirect_i
                         && ((count_q != 2'd2) || pop);

    // Targets must be word aligned and inside the memory window.
    assign redir_ok = (redirect_pc_i[1:0] == 2'b00)
                   && (redirect_pc_i[31:WADDR] == '0);

    assign new_e = '{pc: pc_q, instr: imem_data_i};

    assign imem_en_o   = push;
    assign imem_addr_o = pc_q[WADDR-1:0];
    assign imem_we_o   = 4'b0000;
    assign imem_data_o = 32'h0;
    assign instr_o     = buf0_q.instr;
    assign instr_pc_o  = buf0_q.pc;
    assign fault_o     = (state_q == FAULT);

    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            count_q <= 2'd0;
            buf0_q  <= '0;
            buf1_q  <= '0;
        end else if (redirect_i) begin
            count_q <= 2'd0;
            pc_q    <= redirect_pc_i;
            state_q <= redir_ok ? RUN : FAULT;
        end else begin
            if (state_q == IDLE)
                state_q <= RUN;
            if (push) begin
                pc_q <= pc_q + 32'd4;
                if (pc_q == LAST_PC)
                    state_q <= FAULT;
            end
            unique case ({push, pop})
                2'b11: begin
                    if (count_q == 2'd2) begin
                        buf0_q <= buf1_q;
                        buf1_q <= new_e;
                    end else begin
                        buf0_q <= new_e;
                    end
                end
                2'b10: begin
                    if (count_q == 2'd0)
                        buf0_q <= new_e;
                    else
                        buf1_q <= new_e;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    buf0_q  <= buf1_q;
                    count_q <= count_q - 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: startup, backpressure, redirect,
// fault entry/exit, async reset and sequential overrun.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en;
    logic [9:0]  addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        redirect = 1'b0;
    logic [31:0] rpc = 32'h0;
    logic        valid;
    logic        ready = 1'b1;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic        fault;

    logic        rst2_n = 1'b0;
    logic        en2;
    logic [9:0]  addr2;
    logic [3:0]  we2;
    logic [31:0] wdata2;
    logic [31:0] rdata2;
    logic        valid2;
    logic [31:0] instr2;
    logic [31:0] ipc2;
    logic        fault2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Memory image: each word holds 0x1000_0000 + its byte address.
    assign rdata  = 32'h1000_0000 + {22'b0, addr};
    assign rdata2 = 32'h1000_0000 + {22'b0, addr2};

    if_stage #(.WADDR(10), .RESET_PC(32'h0)) u_dut (
        .clk          (clk),
        .rst_n_i      (rst_n),
        .imem_en_o    (en),
        .imem_addr_o  (addr),
        .imem_we_o    (we),
        .imem_data_o  (wdata),
        .imem_data_i  (rdata),
        .redirect_i   (redirect),
        .redirect_pc_i(rpc),
        .instr_valid_o(valid),
        .instr_ready_i(ready),
        .instr_o      (instr),
        .instr_pc_o   (ipc),
        .fault_o      (fault)
    );

    if_stage #(.WADDR(10), .RESET_PC(32'h3F8)) u_dut2 (
        .clk          (clk),
        .rst_n_i      (rst2_n),
        .imem_en_o    (en2),
        .imem_addr_o  (addr2),
        .imem_we_o    (we2),
        .imem_data_o  (wdata2),
        .imem_data_i  (rdata2),
        .redirect_i   (1'b0),
        .redirect_pc_i(32'h0),
        .instr_valid_o(valid2),
        .instr_ready_i(1'b1),
        .instr_o      (instr2),
        .instr_pc_o   (ipc2),
        .fault_o      (fault2)
    );

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic rd, input logic [31:0] tgt);
        @(negedge clk);
        ready    = rdy;
        redirect = rd;
        rpc      = tgt;
        #1;
    endtask

    task automatic expect_o(input string tag, input logic e,
                            input logic [31:0] a, input logic v,
                            input logic [31:0] p, input logic f);
        check({tag, ".en"}, {31'b0, en}, {31'b0, e});
        if (e)
            check({tag, ".addr"}, {22'b0, addr}, a);
        check({tag, ".valid"}, {31'b0, valid}, {31'b0, v});
        if (v) begin
            check({tag, ".pc"}, ipc, p);
            check({tag, ".instr"}, instr, 32'h1000_0000 + p);
        end
        check({tag, ".fault"}, {31'b0, fault}, {31'b0, f});
    endtask

    task automatic expect_reset(input string tag);
        check({tag, ".en"}, {31'b0, en}, 32'd0);
        check({tag, ".valid"}, {31'b0, valid}, 32'd0);
        check({tag, ".instr"}, instr, 32'd0);
        check({tag, ".pc"}, ipc, 32'd0);
        check({tag, ".fault"}, {31'b0, fault}, 32'd0);
        check({tag, ".addr"}, {22'b0, addr}, 32'd0);
        check({tag, ".we"}, {28'b0, we}, 32'd0);
        check({tag, ".wdata"}, wdata, 32'd0);
    endtask

    initial begin
        #12;
        expect_reset("rst0");

        // Startup with ready high: one instruction per cycle.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        expect_o("idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("e0", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            cyc(1'b1, 1'b0, 32'h0);
            expect_o($sformatf("run%0d", k), 1'b1, 32'(4 * k), 1'b1,
                     32'(4 * (k - 1)), 1'b0);
        end

        // Fill to two entries, then reset asynchronously mid-cycle.
        cyc(1'b0, 1'b0, 32'h0);
        expect_o("fill", 1'b1, 32'd20, 1'b1, 32'd16, 1'b0);
        cyc(1'b0, 1'b0, 32'h0);
        expect_o("full", 1'b0, 32'd24, 1'b1, 32'd16, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        expect_reset("arst");
        @(negedge clk);
        @(negedge clk);

        // Restart with ready low: saturate at two entries.
        rst_n = 1'b1;
        ready = 1'b0;
        #1;
        expect_o("b.idle", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0);
        expect_o("b.e0", 1'b1, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b0, 1'b0, 32'h0);
        expect_o("b.e1", 1'b1, 32'h4, 1'b1, 32'h0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            cyc(1'b0, 1'b0, 32'h0);
            expect_o($sformatf("stall%0d", k), 1'b0, 32'h8, 1'b1,
                     32'h0, 1'b0);
            check("stall.addr", {22'b0, addr}, 32'h8);
        end
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("resume0", 1'b1, 32'h8, 1'b1, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("resume1", 1'b1, 32'hC, 1'b1, 32'h4, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("resume2", 1'b1, 32'h10, 1'b1, 32'h8, 1'b0);

        // Redirect to 0x40 with a full buffer.
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("pre.redir", 1'b1, 32'h14, 1'b1, 32'hC, 1'b0);
        cyc(1'b1, 1'b1, 32'h40);
        expect_o("redir", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("redir+1", 1'b1, 32'h40, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("redir+2", 1'b1, 32'h44, 1'b1, 32'h40, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("redir+3", 1'b1, 32'h48, 1'b1, 32'h44, 1'b0);

        // Misaligned target faults; a good redirect recovers.
        cyc(1'b1, 1'b1, 32'h42);
        expect_o("bad.redir", 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("fault0", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("fault1", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b1, 32'h80);
        expect_o("fix.redir", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("fix+1", 1'b1, 32'h80, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("fix+2", 1'b1, 32'h84, 1'b1, 32'h80, 1'b0);

        // Out-of-range target also faults.
        cyc(1'b1, 1'b1, 32'h400);
        cyc(1'b1, 1'b0, 32'h0);
        expect_o("range", 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);

        // Sequential overrun at the top of memory.
        @(negedge clk);
        rst2_n = 1'b1;
        @(negedge clk);
        #1;
        check("top.e0.en", {31'b0, en2}, 32'd1);
        check("top.e0.addr", {22'b0, addr2}, 32'h3F8);
        @(negedge clk);
        #1;
        check("top.e1.valid", {31'b0, valid2}, 32'd1);
        check("top.e1.pc", ipc2, 32'h3F8);
        check("top.e1.instr", instr2, 32'h1000_03F8);
        check("top.e1.addr", {22'b0, addr2}, 32'h3FC);
        check("top.e1.en", {31'b0, en2}, 32'd1);
        @(negedge clk);
        #1;
        check("top.e2.pc", ipc2, 32'h3FC);
        check("top.e2.instr", instr2, 32'h1000_03FC);
        check("top.e2.fault", {31'b0, fault2}, 32'd1);
        check("top.e2.en", {31'b0, en2}, 32'd0);
        @(negedge clk);
        #1;
        check("top.e3.valid", {31'b0, valid2}, 32'd0);
        check("top.e3.fault", {31'b0, fault2}, 32'd1);
        check("top.e3.en", {31'b0, en2}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction fetch stage that sits directly upstream of the dual-port instruction memory. It owns the program counter, drives port A of the memory as a read-only port, and captures each returned word into a 2-entry prefetch buffer. The buffer presents instructions to decode through a valid/ready handshake. The stage also handles branch/jump redirects, sequential overrun and misaligned targets through a 3-state controller.

## Interface
- WADDR, 10, byte-address width of the instruction memory; must match the memory instance.
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned and below 2**WADDR.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n_i  in  1  reset, asynchronous, active-low.
- imem_en_o  out  1  memory port A enable; high only in cycles where a fetch is pushed.
- imem_addr_o  out  WADDR  byte address, equal to pc_q[WADDR-1:0].
- imem_we_o  out  4  byte write enables; constant 4'b0000.
- imem_data_o  out  32  write data; constant 0.
- imem_data_i  in  32  read data; valid in the same cycle as imem_addr_o (asynchronous read).
- redirect_i  in  1  redirect request from execute (taken branch/jump).
- redirect_pc_i  in  32  redirect target byte address.
- instr_valid_o  out  1  buffer head holds a valid instruction.
- instr_ready_i  in  1  decode accepts the head instruction.
- instr_o  out  32  head instruction word.
- instr_pc_o  out  32  byte address of the head instruction.
- fault_o  out  1  high while the controller is in FAULT.

## Operation
- Controller states: IDLE, RUN, FAULT. Reset enters IDLE. IDLE moves to RUN on the next edge unconditionally.
- pop = instr_valid_o & instr_ready_i.
- push = (state==RUN) & !redirect_i & (count<2 | pop).
- imem_en_o = push.
- On push, store {pc_q, imem_data_i} at the buffer tail and set pc_q <= pc_q + 4 (32-bit arithmetic).
- Buffer is a 2-entry FIFO in program order. count is in 0..2.
- Simultaneous push and pop leaves count unchanged.
- At count 2 with no pop, there is no fetch and pc_q holds.
- instr_valid_o = (count!=0) & !redirect_i.
- instr_o and instr_pc_o always show the head entry.
- Redirect has priority over push and pop. In the redirect cycle, the head is not consumed.
- On a redirect edge, count <= 0 and pc_q <= redirect_pc_i.
- If redirect_pc_i[1:0]!=0 or redirect_pc_i >= 2**WADDR, the redirect enters FAULT; otherwise it enters RUN. This applies from any state, including FAULT.
- Sequential overrun: when a push occurs with pc_q == 2**WADDR-4, the word is pushed normally, then state <= FAULT.
- FAULT: no fetches, and imem_en_o stays 0.
- In FAULT, the buffer keeps draining to decode normally.
- In FAULT, fault_o = 1 and pc_q holds.
- Leave FAULT only by a valid redirect or by reset.
- Reset values: pc_q = RESET_PC, count = 0, buffer entries = 0, state = IDLE.
- Output values in reset: imem_en_o = 0, instr_valid_o = 0, instr_o = 0, instr_pc_o = 0, fault_o = 0.
- Reset asserted mid-operation clears everything immediately (asynchronous). Outputs take their reset values without waiting for a clock edge.

## Timing
- Edge E0 is the first edge after rst_n_i rises: IDLE -> RUN. There is no fetch in the cycle before E0.
- In the cycle after E0, imem_addr_o = RESET_PC and imem_en_o = 1. After E1, instr_valid_o = 1 with instr_pc_o = RESET_PC.
- Steady state with instr_ready_i held high: 1 instruction per cycle, count stays at 1.
- Backpressure: fetching continues until count = 2, then stalls. The first cycle ready returns, the stage pops and pushes together.
- Redirect sampled at edge Er: the target is fetched in the cycle after Er and is valid after Er+1. There are 2 bubble cycles counting the redirect cycle itself.
- Fault entry is visible on fault_o in the cycle after the triggering edge.

## Test plan
- Reset release, ready held high, memory holds word 0x1000_0000+addr: after E1, instr_pc_o steps 0, 4, 8, … with matching instr_o, valid continuously, imem_en_o = 1 every RUN cycle.
- Ready low for 5 cycles, then high: count saturates at 2, imem_addr_o holds at 8, no instruction lost or duplicated; the sequence resumes 0, 4, 8.
- redirect_i with target 0x40 while count = 2: valid is low in the redirect cycle and the next cycle. The next delivered instr_pc_o is 0x40, and the stale 0x0/0x4 entries are never delivered.
- Redirect to 0x42: fault_o = 1 next cycle, imem_en_o stays 0, valid stays 0. A later redirect to 0x80 clears fault_o and delivers 0x80.
- RESET_PC = 2**WADDR-8 with ready high: the stage delivers 0x3F8 and 0x3FC, then fault_o = 1, with no fetch at 0x400.
- Assert rst_n_i low mid-stream with count = 2: all outputs reach reset values before the next edge. After release, the RESET_PC sequence restarts per E0/E1 timing.
